// File: rtl/npc_mem_pkg.sv
// npc_mem_pkg: shared types and lane helpers for the memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, REQ, RESP)
//   mst_e       : master identifiers (IFU, LSU)
//   lane_*      : byte-lane shifts between LSB-justified and 8-byte-aligned views
package npc_mem_pkg;

    localparam int unsigned LANE_BYTES = 8;
    localparam int unsigned OFF_W      = 3;
    localparam int unsigned LANE_BITS  = LANE_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } arb_state_e;

    typedef enum logic {
        MST_IFU = 1'b0,
        MST_LSU = 1'b1
    } mst_e;

    // Move LSB-justified data up onto its byte lane; bytes past bit 63 fall off.
    function automatic logic [LANE_BITS-1:0] lane_shl_data(
        input logic [LANE_BITS-1:0] data,
        input logic [OFF_W-1:0]     off
    );
        return data << {off, 3'b000};
    endfunction

    // Move an LSB-justified byte mask up onto its lanes; bits past bit 7 fall off.
    function automatic logic [LANE_BYTES-1:0] lane_shl_mask(
        input logic [LANE_BYTES-1:0] mask,
        input logic [OFF_W-1:0]      off
    );
        return mask << off;
    endfunction

    // Bring aligned read data back down so the addressed byte lands in bits [7:0].
    function automatic logic [LANE_BITS-1:0] lane_shr_data(
        input logic [LANE_BITS-1:0] data,
        input logic [OFF_W-1:0]     off
    );
        return data >> {off, 3'b000};
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-input round-robin grant.
//   valid[1:0] : request lines, bit 0 = IFU, bit 1 = LSU
//   last       : master granted most recently (mst_e encoding)
//   grant[1:0] : one-hot grant, all-zero when nobody requests
module rr_pick2
    import npc_mem_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie, the master that did not win last time goes first.
            2'b11:   grant = (last == MST_LSU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (IFU read-only, LSU read/write) to one memory port
// arbiter, one outstanding transaction at a time, round-robin on ties.
// Also performs 8-byte lane alignment of address, write data/mask and read data.
//
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   ifu_req_*             : IFU read request (valid/ready/addr)
//   ifu_resp_*            : IFU read response (valid/data, data aligned down)
//   lsu_req_*             : LSU request (valid/ready/addr/wen/wdata/wmask)
//   lsu_resp_*            : LSU response (read data or write acknowledge)
//   mem_req_*             : registered aligned request to the memory port
//   mem_resp_*            : raw aligned response from the memory port
//   busy                  : a transaction is in flight (state is not IDLE)
module mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    // Lane logic assumes 8 byte lanes; only 64 is supported.
    parameter int unsigned DATA_W = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_resp_data,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [LANE_BYTES-1:0] lsu_req_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_resp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [LANE_BYTES-1:0] mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data,

    output logic                  busy
);

    arb_state_e            state_q, state_d;
    mst_e                  last_q, last_d;
    mst_e                  owner_q, owner_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [LANE_BYTES-1:0] wmask_q, wmask_d;

    logic [1:0]            grant;
    logic                  idle;
    logic                  resp_fire;
    logic [OFF_W-1:0]      off;

    rr_pick2 u_rr_pick2 (
        .valid ({lsu_req_valid, ifu_req_valid}),
        .last  (last_q),
        .grant (grant)
    );

    assign idle = (state_q == IDLE);
    assign off  = addr_q[OFF_W-1:0];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;

        unique case (state_q)
            IDLE: begin
                // In IDLE the ready outputs equal the grant, so any grant is a handshake.
                if (grant != 2'b00) begin
                    owner_d = grant[1] ? MST_LSU : MST_IFU;
                    last_d  = grant[1] ? MST_LSU : MST_IFU;
                    addr_d  = grant[1] ? lsu_req_addr : ifu_req_addr;
                    wen_d   = grant[1] & lsu_req_wen;
                    wdata_d = grant[1] ? lsu_req_wdata : '0;
                    wmask_d = grant[1] ? lsu_req_wmask : '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Responses arriving before the request is taken are ignored.
                if (mem_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= MST_LSU;  // so IFU wins the first tie
            owner_q <= MST_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Ready is gated by reset_n so both masters see 0 while reset is held,
    // even though the FSM already sits in IDLE.
    assign ifu_req_ready = reset_n & idle & grant[0];
    assign lsu_req_ready = reset_n & idle & grant[1];

    // Memory request fields come only from registers; alignment is a pure
    // rewiring of the latched values.
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = lane_shl_data(wdata_q, off);
    assign mem_req_wmask = lane_shl_mask(wmask_q, off);

    assign resp_fire      = (state_q == RESP) & mem_resp_valid;
    assign ifu_resp_valid = resp_fire & (owner_q == MST_IFU);
    assign lsu_resp_valid = resp_fire & (owner_q == MST_LSU);

    // Only the owner's valid qualifies the data, so both may share one shifter.
    assign ifu_resp_data  = lane_shr_data(mem_resp_data, off);
    assign lsu_resp_data  = lane_shr_data(mem_resp_data, off);

    assign busy = ~idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. Directed scenarios plus
// randomized transactions, checked against a transaction-level model of the
// grant order and byte-lane movement.
module tb_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [63:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic [63:0] ifu_resp_data;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [63:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [63:0] lsu_req_wdata;
    logic [7:0]  lsu_req_wmask;
    logic        lsu_resp_valid;
    logic [63:0] lsu_resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        busy;

    mem_arbiter #(
        .ADDR_W (64),
        .DATA_W (64)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_data  (ifu_resp_data),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wmask  (lsu_req_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_data  (lsu_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Observed handshake / response timing, sampled mid-cycle.
    int hs_cyc   = 0;
    int prev_hs  = 0;
    int resp_lat = -1;
    always @(negedge clock) begin
        if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) begin
            prev_hs = hs_cyc;
            hs_cyc  = cyc;
        end
        if (ifu_resp_valid || lsu_resp_valid) resp_lat = cyc - hs_cyc;
    end

    int checks_total = 0;
    int checks_pass  = 0;
    int checks_fail  = 0;
    int last_owner   = 1;  // model: 0 = IFU, 1 = LSU

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_pass++;
        else begin
            checks_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Model: who wins given the requesters and the previous winner.
    function automatic int pick(input bit iv, input bit lv, input int last);
        if (iv && lv) return (last == 0) ? 1 : 0;
        if (iv) return 0;
        if (lv) return 1;
        return -1;
    endfunction

    // Model: byte i of LSB-justified data lands in lane i+off; overflow dropped.
    function automatic logic [63:0] lane_up(input logic [63:0] d, input int off);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (i + off < 8) r[(i + off) * 8 +: 8] = d[i * 8 +: 8];
        return r;
    endfunction

    function automatic logic [7:0] mask_up(input logic [7:0] m, input int off);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (i + off < 8) r[i + off] = m[i];
        return r;
    endfunction

    // Model: the byte at lane off comes back as byte 0; upper bytes zero-filled.
    function automatic logic [63:0] lane_down(input logic [63:0] d, input int off);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (i + off < 8) r[i * 8 +: 8] = d[(i + off) * 8 +: 8];
        return r;
    endfunction

    task automatic chk_all_zero(input string ph);
        chk({ph, "_ifu_req_ready"}, ifu_req_ready, 0);
        chk({ph, "_lsu_req_ready"}, lsu_req_ready, 0);
        chk({ph, "_ifu_resp_valid"}, ifu_resp_valid, 0);
        chk({ph, "_lsu_resp_valid"}, lsu_resp_valid, 0);
        chk({ph, "_mem_req_valid"}, mem_req_valid, 0);
        chk({ph, "_mem_req_addr"}, mem_req_addr, 0);
        chk({ph, "_mem_req_wen"}, mem_req_wen, 0);
        chk({ph, "_mem_req_wdata"}, mem_req_wdata, 0);
        chk({ph, "_mem_req_wmask"}, mem_req_wmask, 0);
        chk({ph, "_busy"}, busy, 0);
    endtask

    // One full transaction. Entered at posedge+1 of an IDLE cycle, returns at
    // posedge+1 of the following IDLE cycle. rw = cycles of mem_req_ready low,
    // dw = cycles before mem_resp_valid, bv = request valids held while busy.
    task automatic do_txn(input bit iv, input bit lv, input logic [63:0] ia,
                          input logic [63:0] la, input bit wen, input logic [63:0] wd,
                          input logic [7:0] wm, input int rw, input int dw,
                          input logic [63:0] rdata, input logic [1:0] bv);
        int          own;
        int          off;
        logic [63:0] a;
        logic [63:0] e_wd;
        logic [7:0]  e_wm;
        bit          e_wen;
        own = pick(iv, lv, last_owner);
        ifu_req_valid  = iv;
        lsu_req_valid  = lv;
        ifu_req_addr   = ia;
        lsu_req_addr   = la;
        lsu_req_wen    = wen;
        lsu_req_wdata  = wd;
        lsu_req_wmask  = wm;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_ifu_req_ready", ifu_req_ready, own == 0);
        chk("idle_lsu_req_ready", lsu_req_ready, own == 1);
        last_owner = own;
        a     = (own == 1) ? la : ia;
        off   = int'(a % 8);
        e_wen = (own == 1) && wen;
        e_wd  = (own == 1) ? lane_up(wd, off) : 64'd0;
        e_wm  = (own == 1) ? mask_up(wm, off) : 8'd0;

        for (int k = 0; k <= rw; k++) begin
            next_cycle();
            ifu_req_valid  = bv[0];
            lsu_req_valid  = bv[1];
            mem_req_ready  = (k == rw);
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_data  = {$urandom, $urandom};
            #1;
            chk("req_valid", mem_req_valid, 1);
            chk("req_addr", mem_req_addr, a - (a % 8));
            chk("req_wen", mem_req_wen, e_wen);
            chk("req_wdata", mem_req_wdata, e_wd);
            chk("req_wmask", mem_req_wmask, e_wm);
            chk("req_busy", busy, 1);
            chk("req_ifu_req_ready", ifu_req_ready, 0);
            chk("req_lsu_req_ready", lsu_req_ready, 0);
            chk("req_ifu_resp_valid", ifu_resp_valid, 0);
            chk("req_lsu_resp_valid", lsu_resp_valid, 0);
        end

        for (int k = 0; k <= dw; k++) begin
            next_cycle();
            ifu_req_valid  = bv[0];
            lsu_req_valid  = bv[1];
            mem_req_ready  = 1'($urandom_range(0, 1));
            mem_resp_valid = (k == dw);
            mem_resp_data  = (k == dw) ? rdata : {$urandom, $urandom};
            #1;
            chk("resp_busy", busy, 1);
            chk("resp_mem_req_valid", mem_req_valid, 0);
            chk("resp_ifu_req_ready", ifu_req_ready, 0);
            chk("resp_lsu_req_ready", lsu_req_ready, 0);
            chk("resp_ifu_resp_valid", ifu_resp_valid, (k == dw) && (own == 0));
            chk("resp_lsu_resp_valid", lsu_resp_valid, (k == dw) && (own == 1));
            if (k == dw && own == 0) chk("ifu_resp_data", ifu_resp_data, lane_down(rdata, off));
            if (k == dw && own == 1 && !wen)
                chk("lsu_resp_data", lsu_resp_data, lane_down(rdata, off));
        end

        next_cycle();
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    bit          r_iv, r_lv, r_wen;
    logic [63:0] r_ia, r_la, r_wd, r_rd;
    logic [7:0]  r_wm;
    logic [1:0]  r_bv;

    initial begin
        // Power-on reset, with both masters already requesting.
        reset_n        = 1'b0;
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b1;
        ifu_req_addr   = 64'h8000_0000;
        lsu_req_addr   = 64'h8000_0008;
        lsu_req_wen    = 1'b0;
        lsu_req_wdata  = '0;
        lsu_req_wmask  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD_BEEF_0000_0001;
        #2;
        chk_all_zero("por");
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_resp_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n    = 1'b1;
        last_owner = 1;
        next_cycle();

        // IFU-only read at offset 4.
        do_txn(1, 0, 64'h8000_0004, 64'h0, 0, 64'h0, 8'h00, 1, 1,
               64'h1122_3344_5566_7788, 2'b00);
        // LSU byte write at offset 3.
        do_txn(0, 1, 64'h0, 64'h8000_0013, 1, 64'hAB, 8'h01, 0, 1,
               64'h0, 2'b00);
        // Ties with both masters held valid: IFU, LSU, IFU, LSU.
        for (int i = 0; i < 4; i++) begin
            do_txn(1, 1, 64'h8000_0100 + 64'(i), 64'h8000_0200 + 64'(8 * i), 0,
                   64'h0, 8'h00, 0, 0, {$urandom, $urandom}, 2'b11);
            chk("tie_order", 64'(last_owner), 64'(i % 2));
        end
        // Backpressure: memory stalls 5 cycles while LSU keeps requesting.
        do_txn(0, 1, 64'h0, 64'h8000_0306, 1, 64'h1234_5678, 8'h03, 5, 0,
               64'h0, 2'b10);
        do_txn(0, 1, 64'h0, 64'h8000_0301, 0, 64'h0, 8'h00, 0, 0,
               64'hF0E1_D2C3_B4A5_9687, 2'b00);
        // Zero-wait memory, back-to-back LSU reads.
        do_txn(0, 1, 64'h0, 64'h8000_0400, 0, 64'h0, 8'h00, 0, 0,
               64'h0102_0304_0506_0708, 2'b00);
        do_txn(0, 1, 64'h0, 64'h8000_0402, 0, 64'h0, 8'h00, 0, 0,
               64'h1112_1314_1516_1718, 2'b00);
        chk("accept_to_resp_latency", 64'(resp_lat), 64'd2);
        chk("back_to_back_spacing", 64'(hs_cyc - prev_hs), 64'd3);

        // Reset while waiting for a response.
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_req_addr  = 64'h8000_0500;
        lsu_req_addr  = 64'h8000_0508;
        lsu_req_wen   = 1'b1;
        lsu_req_wdata = 64'hFF;
        lsu_req_wmask = 8'hFF;
        next_cycle();
        mem_req_ready = 1'b1;
        #1;
        chk("rst_pre_mem_req_valid", mem_req_valid, 1);
        next_cycle();
        mem_req_ready = 1'b0;
        #1;
        chk("rst_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_in_resp");
        mem_resp_valid = 1'b1;
        #1;
        chk_all_zero("rst_stale");
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_resp_valid = 1'b0;
        next_cycle();
        reset_n        = 1'b1;
        last_owner     = 1;
        mem_resp_valid = 1'b1;  // stale response arriving in IDLE
        #1;
        chk("stale_ifu_resp_valid", ifu_resp_valid, 0);
        chk("stale_lsu_resp_valid", lsu_resp_valid, 0);
        chk("stale_busy", busy, 0);
        next_cycle();
        mem_resp_valid = 1'b0;
        do_txn(1, 1, 64'h8000_0605, 64'h8000_0700, 0, 64'h0, 8'h00, 0, 1,
               64'hAABB_CCDD_EEFF_0011, 2'b11);
        chk("post_reset_tie_ifu", 64'(last_owner), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            r_iv  = 1'($urandom_range(0, 1));
            r_lv  = 1'($urandom_range(0, 1));
            if (!r_iv && !r_lv) r_lv = 1'b1;
            r_ia  = 64'h8000_0000 + 64'($urandom_range(0, 4095));
            r_la  = 64'h8000_0000 + 64'($urandom_range(0, 4095));
            r_wen = 1'($urandom_range(0, 1));
            r_wd  = {$urandom, $urandom};
            r_wm  = 8'($urandom);
            r_rd  = {$urandom, $urandom};
            r_bv  = 2'($urandom);
            do_txn(r_iv, r_lv, r_ia, r_la, r_wen, r_wd, r_wm,
                   $urandom_range(0, 3), $urandom_range(0, 3), r_rd, r_bv);
        end

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
